// File: rtl/sprite_addr_gen_pkg.sv
// rtl/sprite_addr_gen_pkg.sv - shared descriptor type and default constants for sprite_addr_gen
package sprite_addr_gen_pkg;

    localparam int CNT_W_DEF     = 10;
    localparam int ADDR_W_DEF    = 17;
    localparam int H_WRAP_DEF    = 850;
    localparam int ROM_DEPTH_DEF = 27000;

    typedef struct packed {
        logic [CNT_W_DEF-1:0]  loc_h;
        logic [CNT_W_DEF-1:0]  loc_v;
        logic [CNT_W_DEF-1:0]  width;
        logic [CNT_W_DEF-1:0]  height;
        logic [ADDR_W_DEF-1:0] base;
        logic                  en;
    } spr_desc_t;

endpackage

// File: rtl/spr_hit_calc.sv
// rtl/spr_hit_calc.sv - combinational inside test and pixel offset for one sprite
module spr_hit_calc #(
    parameter int CNT_W  = 10,
    parameter int ADDR_W = 17,
    parameter int H_WRAP = 850
) (
    input  logic [CNT_W-1:0]  h_cnt,
    input  logic [CNT_W-1:0]  v_cnt,
    input  logic [CNT_W-1:0]  loc_h,
    input  logic [CNT_W-1:0]  loc_v,
    input  logic [CNT_W-1:0]  width,
    input  logic [CNT_W-1:0]  height,
    input  logic              en,
    output logic              hit,
    output logic [ADDR_W-1:0] off
);

    localparam logic [CNT_W:0] HW = (CNT_W+1)'(H_WRAP);

    logic [CNT_W:0] h_ext, v_ext, lh_ext, lv_ext, h_end, v_end, dx, dy;
    logic           in_main, in_wrap, in_v;

    always_comb begin
        h_ext   = {1'b0, h_cnt};
        v_ext   = {1'b0, v_cnt};
        lh_ext  = {1'b0, loc_h};
        lv_ext  = {1'b0, loc_v};
        h_end   = lh_ext + {1'b0, width};
        v_end   = lv_ext + {1'b0, height};
        in_main = (h_ext >= lh_ext) && (h_ext < h_end);
        // Sprite running off the right edge reappears at the start of the line
        in_wrap = (h_end > HW) && (h_ext < (h_end - HW));
        in_v    = (v_ext >= lv_ext) && (v_ext < v_end);
        dx      = in_main ? (h_ext - lh_ext) : (h_ext + HW - lh_ext);
        dy      = v_ext - lv_ext;
        hit     = en && (in_main || in_wrap) && in_v && (width != '0) && (height != '0);
        off     = ADDR_W'(dy) * ADDR_W'(width) + ADDR_W'(dx);
    end

endmodule

// File: rtl/sprite_addr_gen.sv
// rtl/sprite_addr_gen.sv - double-buffered sprite descriptors with 2-stage pixel address pipeline
module sprite_addr_gen
    import sprite_addr_gen_pkg::*;
#(
    parameter int N_SPR     = 4,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int H_WRAP    = H_WRAP_DEF,
    parameter int ROM_DEPTH = ROM_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CNT_W-1:0]         h_cnt,
    input  logic [CNT_W-1:0]         v_cnt,
    input  logic                     frame_start,
    input  logic                     upd_we,
    input  logic [$clog2(N_SPR)-1:0] upd_idx,
    input  logic [CNT_W-1:0]         upd_loc_h,
    input  logic [CNT_W-1:0]         upd_loc_v,
    input  logic [CNT_W-1:0]         upd_width,
    input  logic [CNT_W-1:0]         upd_height,
    input  logic [ADDR_W-1:0]        upd_base,
    input  logic                     upd_en,
    output logic [ADDR_W-1:0]        pixel_addr,
    output logic                     hit,
    output logic [$clog2(N_SPR)-1:0] spr_id,
    output logic                     addr_err
);

    localparam int IDX_W = $clog2(N_SPR);

    spr_desc_t          pend_q [N_SPR];
    spr_desc_t          pend_d [N_SPR];
    spr_desc_t          act_q  [N_SPR];
    spr_desc_t          act_d  [N_SPR];

    logic               hit_c  [N_SPR];
    logic [ADDR_W-1:0]  off_c  [N_SPR];
    logic               hit1_q [N_SPR];
    logic [ADDR_W-1:0]  off1_q [N_SPR];
    logic [ADDR_W-1:0]  base1_q[N_SPR];

    logic               found, oor;
    logic [IDX_W-1:0]   sel_id;
    logic [ADDR_W-1:0]  sel_addr;
    logic [ADDR_W-1:0]  addr_d, addr_q;
    logic               hit_d, hit_q;
    logic [IDX_W-1:0]   spr_id_d, spr_id_q;
    logic               err_d, err_q;

    // Active copy reads the pre-write pending bank, so a same-cycle write waits a frame
    always_comb begin
        pend_d = pend_q;
        act_d  = act_q;
        if (frame_start) begin
            act_d = pend_q;
        end
        if (upd_we) begin
            pend_d[upd_idx] = '{loc_h: upd_loc_h, loc_v: upd_loc_v, width: upd_width,
                                height: upd_height, base: upd_base, en: upd_en};
        end
    end

    for (genvar g = 0; g < N_SPR; g++) begin : g_spr
        spr_hit_calc #(
            .CNT_W  (CNT_W),
            .ADDR_W (ADDR_W),
            .H_WRAP (H_WRAP)
        ) u_calc (
            .h_cnt  (h_cnt),
            .v_cnt  (v_cnt),
            .loc_h  (act_q[g].loc_h),
            .loc_v  (act_q[g].loc_v),
            .width  (act_q[g].width),
            .height (act_q[g].height),
            .en     (act_q[g].en),
            .hit    (hit_c[g]),
            .off    (off_c[g])
        );
    end

    always_comb begin
        found    = 1'b0;
        sel_id   = '0;
        sel_addr = '0;
        for (int i = 0; i < N_SPR; i++) begin
            if (!found && hit1_q[i]) begin
                found    = 1'b1;
                sel_id   = IDX_W'(i);
                sel_addr = base1_q[i] + off1_q[i];
            end
        end
        oor      = found && (sel_addr >= ADDR_W'(ROM_DEPTH));
        hit_d    = found && !oor;
        spr_id_d = hit_d ? sel_id : '0;
        addr_d   = hit_d ? sel_addr : '0;
        err_d    = err_q | oor;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_SPR; i++) begin
                pend_q[i]  <= '0;
                act_q[i]   <= '0;
                hit1_q[i]  <= 1'b0;
                off1_q[i]  <= '0;
                base1_q[i] <= '0;
            end
            addr_q   <= '0;
            hit_q    <= 1'b0;
            spr_id_q <= '0;
            err_q    <= 1'b0;
        end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
            for (int i = 0; i < N_SPR; i++) begin
                hit1_q[i]  <= hit_c[i];
                off1_q[i]  <= off_c[i];
                base1_q[i] <= act_q[i].base;
            end
            addr_q   <= addr_d;
            hit_q    <= hit_d;
            spr_id_q <= spr_id_d;
            err_q    <= err_d;
        end
    end

    assign pixel_addr = addr_q;
    assign hit        = hit_q;
    assign spr_id     = spr_id_q;
    assign addr_err   = err_q;

endmodule
